matrix_bus_regbank: RTL
=======================

// Module: matrix_bus_regbank
// PURPOSE
//  Parametrised system-bus register bank for the matrix-multiply cores: decodes
//  N_REGS word addresses above BASE_ADDR and owns their write registers. Read
//  responses are registered, with programmable latency and an error flag.
//  Sits between the system-bus interconnect and a core's coefficient/status ports.
// PARAMETERS
//  AW        20           bus address width
//  DW        32           data width
//  N_REGS    12           mapped words; word i at BASE_ADDR + 4*i
//  BASE_ADDR 20'h00000    window base, must be 4-aligned
//  RO_MASK   12'h000      bit i = 1: word i read-only, reads return reg_i slice i
//  RD_LAT    1            read latency in cycles from request to ack, 1..4
// PORTS
//  clk_i       in   1          clock
//  rstn_i      in   1          reset, asynchronous, active-low
//  sys_addr    in   AW         byte address
//  sys_wdata   in   DW         write data
//  sys_wen     in   1          write strobe, one-cycle pulse
//  sys_ren     in   1          read strobe, one-cycle pulse
//  sys_rdata   out  DW         read data, valid only while sys_ack=1
//  sys_ack     out  1          one-cycle completion pulse
//  sys_err     out  1          qualifies sys_ack: unmapped, misaligned or RO write
//  reg_o       out  N_REGS*DW  write registers, word i at [i*DW +: DW]
//  reg_i       in   N_REGS*DW  status readback for RO words
//  wr_pulse_o  out  N_REGS     one-cycle pulse per word, same cycle reg_o updates
// BEHAVIOUR
//  - Reset: reg_o, sys_rdata, sys_ack, sys_err and wr_pulse_o all 0. FSM -> IDLE.
//  - Decode: off = sys_addr - BASE_ADDR. hit = (off[1:0]==0) && (off>>2) < N_REGS.
//    idx = off>>2. Subtraction is unsigned; an underflow gives no hit.
//  - FSM states: IDLE, RD_WAIT, RESP. Strobes are sampled only in IDLE.
//    Strobes arriving in RD_WAIT or RESP are ignored: no ack, no state change.
//  - Write, taken in IDLE, latency 1:
//    - hit && !RO_MASK[idx]: at the next edge, reg_o[idx] <= sys_wdata,
//      wr_pulse_o[idx]=1, sys_ack=1, sys_err=0.
//    - Otherwise: sys_ack=1, sys_err=1, no register change, no pulse.
//    - Stays in IDLE, so back-to-back writes run every cycle.
//  - Read, taken in IDLE:
//    - Latch idx/hit. Source: reg_o[idx] if RW, reg_i[idx] if RO.
//    - The source value is sampled at the request edge.
//    - RD_LAT=1: go straight to RESP. Otherwise RD_WAIT for RD_LAT-1 cycles, then RESP.
//    - RESP lasts one cycle: sys_ack=1, sys_rdata=sampled value, then IDLE.
//    - Miss: sys_rdata=0, sys_err=1. A read of an RO word is legal (err=0).
//  - sys_wen and sys_ren together: the write is performed and the read is dropped.
//  - sys_rdata returns to 0 whenever sys_ack=0.
//  - wr_pulse_o is one-hot or zero.
//  - Reset asserted mid-read: the transaction is discarded, no ack is issued,
//    and all outputs clear asynchronously.
//  - RO words in reg_o hold 0 permanently.
// STRUCTURE
//  - Package matrix_bus_pkg holds:
//    - the state typedef {IDLE, RD_WAIT, RESP};
//    - a constant SYS_AW=20;
//    - a function word_index(addr, base).
//  - Sub-module matrix_bus_decode, combinational: addr -> {hit, idx, ro}.
//    Instantiated once.
//  - The regbank holds the FSM, the latency counter (2 bits), reg storage and
//    the response registers.
// TESTING (N_REGS=12, BASE_ADDR=20'h00100, RO_MASK=12'h800, RD_LAT=2 unless stated)
//  1 Write 0xDEADBEEF @0x108 -> next cycle reg_o word2=0xDEADBEEF,
//    wr_pulse_o=12'h004, ack=1, err=0.
//  2 Read @0x108 -> ack exactly 2 cycles after strobe, rdata=0xDEADBEEF, err=0.
//  3 Write @0x12C (word 11, RO) -> ack=1, err=1, reg_o unchanged.
//    Then read @0x12C with reg_i word11=0x5A5A0001 -> rdata=0x5A5A0001, err=0.
//  4 Read @0x130, @0x0FC, @0x102 -> each gives ack with err=1, rdata=0.
//  5 Writes to words 0,1,2 on consecutive cycles -> three acks, pulses 1,2,4 in
//    order; a ren issued the cycle after a read strobe -> ignored, one ack only.
//  6 rstn_i low during RD_WAIT -> no ack, all outputs 0 that cycle, reg_o=0.
//    After release, the read @0x100 returns 0.

Source files
------------

// File: rtl/matrix_bus_pkg.sv
// Shared types and helpers for the matrix-core system-bus register bank.
package matrix_bus_pkg;

  // Transaction FSM: IDLE accepts strobes, RD_WAIT stretches read latency,
  // RESP presents the one-cycle read acknowledge.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  // Default system-bus address width.
  localparam int SYS_AW = 20;

  // Word index of a byte address relative to a window base.
  // The subtraction wraps on underflow; callers must qualify with addr >= base.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return {2'b00, off[31:2]};
  endfunction

endpackage

// File: rtl/matrix_bus_decode.sv
// Combinational address decode: byte address -> {hit, word index, read-only}.
module matrix_bus_decode
  import matrix_bus_pkg::*;
#(
  parameter int                AW        = SYS_AW,
  parameter int                N_REGS    = 12,
  parameter logic [AW-1:0]     BASE_ADDR = '0,
  parameter logic [N_REGS-1:0] RO_MASK   = '0,
  parameter int                IW        = 4
) (
  input  logic [AW-1:0] addr_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o,
  output logic          ro_o
);

  logic [31:0] addr_ext;
  logic [31:0] base_ext;
  logic [31:0] widx;
  logic        hit;

  assign addr_ext = 32'(addr_i);
  assign base_ext = 32'(BASE_ADDR);

  // Hit needs no underflow, word alignment relative to the base, and an in-range index.
  always_comb begin
    widx  = word_index(addr_ext, base_ext);
    hit   = (addr_ext >= base_ext) &&
            (addr_ext[1:0] == base_ext[1:0]) &&
            (widx < 32'(N_REGS));
    idx_o = widx[IW-1:0];
    hit_o = hit;
    ro_o  = 1'b0;
    for (int i = 0; i < N_REGS; i++) begin
      if (hit && (widx[IW-1:0] == IW'(i))) ro_o = RO_MASK[i];
    end
  end

endmodule

// File: rtl/matrix_bus_regbank.sv
// System-bus register bank: N_REGS mapped words, registered read responses
// with programmable latency, error flag on unmapped/misaligned/RO-write access.
//
// Handshake: sys_wen / sys_ren are one-cycle request pulses, accepted only while
// the FSM is IDLE (requests in RD_WAIT/RESP are dropped silently). Every accepted
// request produces exactly one one-cycle sys_ack; sys_err and sys_rdata are
// meaningful only in that cycle, and sys_rdata is 0 whenever sys_ack is 0.
module matrix_bus_regbank
  import matrix_bus_pkg::*;
#(
  parameter int                AW        = SYS_AW,
  parameter int                DW        = 32,
  parameter int                N_REGS    = 12,
  parameter logic [AW-1:0]     BASE_ADDR = '0,
  parameter logic [N_REGS-1:0] RO_MASK   = '0,
  parameter int                RD_LAT    = 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [AW-1:0]        sys_addr,
  input  logic [DW-1:0]        sys_wdata,
  input  logic                 sys_wen,
  input  logic                 sys_ren,
  output logic [DW-1:0]        sys_rdata,
  output logic                 sys_ack,
  output logic                 sys_err,
  output logic [N_REGS*DW-1:0] reg_o,
  input  logic [N_REGS*DW-1:0] reg_i,
  output logic [N_REGS-1:0]    wr_pulse_o,
  output state_t               dbg_state_o
);

  localparam int IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  state_t              state_q, state_d;
  logic [1:0]          lat_q, lat_d;
  logic [DW-1:0]       rd_data_q, rd_data_d;
  logic                rd_err_q, rd_err_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [N_REGS-1:0]   pulse_q, pulse_d;
  logic [DW-1:0]       regs_q [N_REGS];
  logic [DW-1:0]       regs_d [N_REGS];

  logic                hit;
  logic                ro;
  logic [IW-1:0]       idx;
  logic [DW-1:0]       rw_val;
  logic [DW-1:0]       ro_val;
  logic [DW-1:0]       rd_src;

  matrix_bus_decode #(
    .AW        (AW),
    .N_REGS    (N_REGS),
    .BASE_ADDR (BASE_ADDR),
    .RO_MASK   (RO_MASK),
    .IW        (IW)
  ) u_decode (
    .addr_i (sys_addr),
    .hit_o  (hit),
    .idx_o  (idx),
    .ro_o   (ro)
  );

  // Read source mux: RW words come from our own storage, RO words from reg_i.
  always_comb begin
    rw_val = '0;
    ro_val = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (idx == IW'(i)) begin
        rw_val = regs_q[i];
        ro_val = reg_i[i*DW +: DW];
      end
    end
    rd_src = hit ? (ro ? ro_val : rw_val) : '0;
  end

  // Next-state, register writes and response generation.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    rd_data_d = rd_data_q;
    rd_err_d  = rd_err_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    pulse_d   = '0;
    regs_d    = regs_q;
    case (state_q)
      IDLE: begin
        if (sys_wen) begin
          // Write wins over a simultaneous read; always completes next cycle.
          ack_d = 1'b1;
          if (hit && !ro) begin
            for (int i = 0; i < N_REGS; i++) begin
              if (idx == IW'(i)) begin
                regs_d[i]  = sys_wdata;
                pulse_d[i] = 1'b1;
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (sys_ren) begin
          // Source is captured at the request edge, independent of latency.
          rd_data_d = rd_src;
          rd_err_d  = !hit;
          if (RD_LAT <= 1) begin
            state_d = RESP;
            ack_d   = 1'b1;
            rdata_d = rd_src;
            err_d   = !hit;
          end else begin
            state_d = RD_WAIT;
            lat_d   = 2'(RD_LAT - 2);
          end
        end
      end
      RD_WAIT: begin
        if (lat_q == 2'd0) begin
          state_d = RESP;
          ack_d   = 1'b1;
          rdata_d = rd_data_q;
          err_d   = rd_err_q;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, storage and response registers; reset discards any read in flight.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      lat_q     <= 2'd0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      pulse_q   <= pulse_d;
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_reg_out
    assign reg_o[g*DW +: DW] = regs_q[g];
  end

  assign sys_ack     = ack_q;
  assign sys_err     = err_q;
  assign sys_rdata   = rdata_q;
  assign wr_pulse_o  = pulse_q;
  assign dbg_state_o = state_q;

endmodule
